// File: rtl/fetch_defs.sv
// Shared definitions for the fetch stage: state encodings, instruction width
// and the default reset PC.
package fetch_defs;

    localparam int unsigned INSTR_W          = 32;
    localparam int unsigned RESET_PC_DEFAULT = 0;

    typedef enum logic [1:0] {
        FS_RUN    = 2'd0,
        FS_HALTED = 2'd1,
        FS_FAULT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters: delivered instructions and bubble cycles.
// Both wrap modulo 2^32 and clear on synchronous reset.
module fetch_perf_ctr
    import fetch_defs::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_inc,
    input  logic               bubble_inc,
    output logic [INSTR_W-1:0] fetch_count,
    output logic [INSTR_W-1:0] bubble_count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (fetch_inc)  fetch_count  <= fetch_count + 1'b1;
            if (bubble_inc) bubble_count <= bubble_count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers instr_in into the IF register,
// handles stall/redirect/halt/fault. Optional counters under FETCH_PERF_EN.
module fetch_unit
    import fetch_defs::*;
#(
    parameter int unsigned RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    input  logic               halt_req,
    output logic [31:0]        pc,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic [1:0]         fetch_state,
    output logic [31:0]        fetch_count,
    output logic [31:0]        bubble_count
);

    localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d, pc_next;
    logic               if_valid_q, if_valid_d;
    logic [31:0]        if_pc_q, if_pc_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;

    assign pc_next = pc_q + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FS_RUN;
            pc_q       <= 32'(RESET_PC);
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        case (state_q)
            FS_RUN: begin
                if (halt_req) begin
                    state_d    = FS_HALTED;
                    if_valid_d = 1'b0;
                end else if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    if (redirect_target >= DEPTH) state_d = FS_FAULT;
                    else                          pc_d    = redirect_target;
                end else if (!stall) begin
                    // Current word is delivered even when the next PC faults.
                    if_pc_d    = pc_q;
                    if_instr_d = instr_in;
                    if_valid_d = 1'b1;
                    if (pc_next >= DEPTH) state_d = FS_FAULT;
                    else                  pc_d    = pc_next;
                end
            end
            FS_HALTED: begin
                if_valid_d = 1'b0;
            end
            default: begin
                // Covers FS_FAULT and the unused encoding 3.
                state_d    = FS_FAULT;
                if_valid_d = 1'b0;
            end
        endcase
    end

    assign pc          = pc_q;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign fetch_state = (state_q == FS_RUN || state_q == FS_HALTED) ? state_q : FS_FAULT;

`ifdef FETCH_PERF_EN
    logic run, hold, load;
    assign run  = (state_q == FS_RUN);
    assign hold = stall && !redirect_valid && !halt_req;
    assign load = run && !halt_req && !redirect_valid && !stall;

    fetch_perf_ctr u_perf (
        .clk          (clk),
        .reset        (reset),
        .fetch_inc    (load),
        .bubble_inc   (run && (!if_valid_q || hold)),
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
    );
`else
    assign fetch_count  = '0;
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, halt_req;
    logic [31:0] redirect_target, pc, instr_in, if_pc, if_instr;
    logic        if_valid;
    logic [1:0]  fetch_state;
    logic [31:0] fetch_count, bubble_count;

    logic [31:0] mem [256];

    int passed = 0;
    int total  = 0;

    // behavioural model
    logic [31:0] m_pc, m_ifpc, m_ifinstr, m_fetch, m_bubble;
    logic        m_valid;
    int          m_state;

    always #5 clk = ~clk;

    assign instr_in = (pc < 32'd256) ? mem[pc[7:0]] : 32'hDEAD_BEEF;

    fetch_unit #(.RESET_PC(0), .MEM_DEPTH(256)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .pc              (pc),
        .instr_in        (instr_in),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .fetch_state     (fetch_state),
        .fetch_count     (fetch_count),
        .bubble_count    (bubble_count)
    );

    // Apply one cycle of inputs, advance the model by the spec rules, then
    // return #1 after the edge so outputs can be sampled.
    task automatic step(input bit rst, input bit st, input bit rv,
                        input logic [31:0] tgt, input bit hq);
        reset = rst; stall = st; redirect_valid = rv;
        redirect_target = tgt; halt_req = hq;
        if (rst) begin
            m_pc = 0; m_valid = 0; m_ifpc = 0; m_ifinstr = 0;
            m_state = 0; m_fetch = 0; m_bubble = 0;
        end else if (m_state == 0) begin
            if (!m_valid || (st && !rv && !hq)) m_bubble = m_bubble + 1;
            if (hq) begin
                m_state = 1; m_valid = 0;
            end else if (rv) begin
                m_valid = 0;
                if (tgt >= 256) m_state = 2;
                else            m_pc = tgt;
            end else if (!st) begin
                m_ifpc = m_pc; m_ifinstr = mem[m_pc[7:0]]; m_valid = 1;
                m_fetch = m_fetch + 1;
                if (m_pc + 1 >= 256) m_state = 2;
                else                 m_pc = m_pc + 1;
            end
        end else begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 32'd9, 0);
        total++; if (pc !== 32'd0) $display("FAIL reset_pc got %0d want 0", pc); else passed++;
        total++; if (if_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", if_valid); else passed++;
        total++; if (if_pc !== 32'd0 || if_instr !== 32'd0)
            $display("FAIL reset_if got pc=%0d instr=%h want 0/0", if_pc, if_instr); else passed++;
        total++; if (fetch_state !== 2'd0) $display("FAIL reset_state got %0d want 0", fetch_state); else passed++;
        total++; if (fetch_count !== 32'd0 || bubble_count !== 32'd0)
            $display("FAIL reset_ctr got %0d/%0d want 0/0", fetch_count, bubble_count); else passed++;
    endtask

    task automatic test_freerun();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            total++;
            if (if_valid !== 1'b1 || if_pc !== 32'(i) || if_instr !== 32'h1000_0000 + 32'(i) || pc !== 32'(i + 1))
                $display("FAIL freerun_%0d got v=%0b ifpc=%0d instr=%h pc=%0d want 1/%0d/%h/%0d",
                         i, if_valid, if_pc, if_instr, pc, i, 32'h1000_0000 + 32'(i), i + 1);
            else passed++;
        end
`ifdef FETCH_PERF_EN
        total++; if (fetch_count !== 32'd3 || bubble_count !== 32'd1)
            $display("FAIL perf_freerun got %0d/%0d want 3/1", fetch_count, bubble_count); else passed++;
`else
        total++; if (fetch_count !== 32'd0 || bubble_count !== 32'd0)
            $display("FAIL perf_tied got %0d/%0d want 0/0", fetch_count, bubble_count); else passed++;
`endif
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            total++;
            if (pc !== 32'd6 || if_pc !== 32'd5 || if_instr !== 32'h1000_0005 || if_valid !== 1'b1)
                $display("FAIL stall_hold_%0d got pc=%0d ifpc=%0d instr=%h v=%0b want 6/5/10000005/1",
                         i, pc, if_pc, if_instr, if_valid);
            else passed++;
        end
        step(0, 0, 0, 0, 0);
        total++; if (if_pc !== 32'd6 || if_valid !== 1'b1)
            $display("FAIL stall_release got ifpc=%0d v=%0b want 6/1", if_pc, if_valid); else passed++;
    endtask

    task automatic test_redirect();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
        total++; if (pc !== 32'd10) $display("FAIL redir_setup got pc=%0d want 10", pc); else passed++;
        step(0, 0, 1, 32'd40, 0);
        total++; if (pc !== 32'd40 || if_valid !== 1'b0)
            $display("FAIL redir got pc=%0d v=%0b want 40/0", pc, if_valid); else passed++;
        step(0, 0, 0, 0, 0);
        total++; if (if_pc !== 32'd40 || if_valid !== 1'b1 || pc !== 32'd41)
            $display("FAIL redir_next got ifpc=%0d v=%0b pc=%0d want 40/1/41", if_pc, if_valid, pc); else passed++;
        step(0, 1, 1, 32'd20, 0);
        total++; if (pc !== 32'd20 || if_valid !== 1'b0)
            $display("FAIL redir_stall got pc=%0d v=%0b want 20/0", pc, if_valid); else passed++;
    endtask

    task automatic test_halt();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        total++; if (fetch_state !== 2'd1 || pc !== 32'd7 || if_valid !== 1'b0)
            $display("FAIL halt got st=%0d pc=%0d v=%0b want 1/7/0", fetch_state, pc, if_valid); else passed++;
        step(0, 0, 1, 32'd3, 0);
        total++; if (fetch_state !== 2'd1 || pc !== 32'd7)
            $display("FAIL halt_redir got st=%0d pc=%0d want 1/7", fetch_state, pc); else passed++;
        step(1, 0, 0, 0, 0);
        total++; if (fetch_state !== 2'd0 || pc !== 32'd0)
            $display("FAIL halt_reset got st=%0d pc=%0d want 0/0", fetch_state, pc); else passed++;
    endtask

    task automatic test_fault();
        step(0, 0, 1, 32'd255, 0);
        step(0, 0, 0, 0, 0);
        total++; if (if_pc !== 32'd255 || if_valid !== 1'b1 || fetch_state !== 2'd2 || pc !== 32'd255)
            $display("FAIL fault_adv got ifpc=%0d v=%0b st=%0d pc=%0d want 255/1/2/255",
                     if_pc, if_valid, fetch_state, pc); else passed++;
        step(0, 0, 1, 32'd4, 0);
        total++; if (if_valid !== 1'b0 || fetch_state !== 2'd2 || pc !== 32'd255)
            $display("FAIL fault_stay got v=%0b st=%0d pc=%0d want 0/2/255", if_valid, fetch_state, pc); else passed++;
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 32'd300, 0);
        total++; if (fetch_state !== 2'd2 || pc !== 32'd0 || if_valid !== 1'b0)
            $display("FAIL fault_redir got st=%0d pc=%0d v=%0b want 2/0/0", fetch_state, pc, if_valid); else passed++;
        step(1, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        step(1, 0, 0, 0, 0);
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, 32'($urandom_range(0, 270)),
                 $urandom_range(0, 99) == 0);
            total++;
            if (pc !== m_pc || if_valid !== m_valid || if_pc !== m_ifpc || if_instr !== m_ifinstr ||
                fetch_state !== 2'(m_state)
`ifdef FETCH_PERF_EN
                || fetch_count !== m_fetch || bubble_count !== m_bubble
`endif
               )
                $display("FAIL random_%0d got pc=%0d v=%0b ifpc=%0d instr=%h st=%0d fc=%0d bc=%0d want %0d/%0b/%0d/%h/%0d/%0d/%0d",
                         c, pc, if_valid, if_pc, if_instr, fetch_state, fetch_count, bubble_count,
                         m_pc, m_valid, m_ifpc, m_ifinstr, m_state, m_fetch, m_bubble);
            else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        reset = 1; stall = 0; redirect_valid = 0; redirect_target = 0; halt_req = 0;
        test_reset();
        test_freerun();
        test_stall();
        test_redirect();
        test_halt();
        test_fault();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter and drives the word index into instruction memory.
- Registers the returned instruction into an IF output register (pc, instr, valid) consumed by decode.
- Handles stall, branch/jump redirect with squash, halt, and out-of-range PC fault.

Parameters:
- RESET_PC, 0, word index loaded into the PC on reset.
- MEM_DEPTH, 256, number of instruction words; a PC at or above this value is a fault.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  decode cannot accept; hold PC and the IF register.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  32  word index of the new PC.
- halt_req  in  1  stop fetching permanently until reset.
- pc  out  32  current word index, driven to instruction memory.
- instr_in  in  32  instruction word returned combinationally for pc.
- if_valid  out  1  IF register holds a live instruction.
- if_pc  out  32  PC of the instruction in the IF register.
- if_instr  out  32  instruction in the IF register.
- fetch_state  out  2  0=RUN, 1=HALTED, 2=FAULT.
- fetch_count  out  32  fetched-instruction count (see Optional Feature).
- bubble_count  out  32  squash/stall bubble count (see Optional Feature).

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
- Reset values: pc=RESET_PC, if_valid=0, if_pc=0, if_instr=0, fetch_state=RUN, both counters 0.
- Latency: instr_in at pc is captured into the IF register on the next edge, so if_* lags pc by one cycle.
- Per-edge priority in RUN: reset > halt_req > redirect_valid > stall > advance.
  - halt_req: state becomes HALTED; pc frozen; if_valid<=0.
  - redirect_valid: pc<=redirect_target; if_valid<=0, squashing the wrong-path word. This overrides stall.
  - stall (no redirect): pc and all if_* hold their values.
  - advance: if_pc<=pc; if_instr<=instr_in; if_valid<=1; pc<=pc+1.
- Arithmetic: pc+1 is 32-bit modulo. No byte addressing; pc is a word index.
- Fault check, applied to the value about to be loaded into pc (pc+1 or redirect_target):
  - If the value is >= MEM_DEPTH, state becomes FAULT and pc is not updated.
  - On an advance, the current word is still captured into the IF register (if_valid<=1).
  - From the next cycle on, if_valid=0.
  - Example: pc=255 advancing with MEM_DEPTH=256 delivers word 255, then enters FAULT.
- HALTED and FAULT are absorbing: only reset exits them. While in either, if_valid=0 and stall/redirect are ignored.
- A stalled valid instruction is never lost or duplicated. if_valid drops only on squash, halt, fault, or reset.
- Reset mid-stall or mid-redirect: reset wins and all state returns to reset values.
- The FSM is encoded in fetch_state. Value 3 is unreachable; if ever entered, treat it as FAULT.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - fetch_count increments on every edge where the IF register loads a valid instruction.
  - bubble_count increments on every RUN edge where the IF register is valid=0 or held by stall.
  - Both counters wrap modulo 2^32 and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are synthesized. The port list is unchanged.

Decomposition:
- Shared package/include `fetch_defs`:
  - State encodings FS_RUN=2'd0, FS_HALTED=2'd1, FS_FAULT=2'd2.
  - Instruction width constant 32.
  - RESET_PC default value.
- Natural sub-module `fetch_perf_ctr`: the two counters, instantiated only under FETCH_PERF_EN.
- PC logic, FSM and the IF register stay in fetch_unit.

Test Plan:
- Reset then 4 free-run cycles with memory word i = 32'h1000_0000+i:
  - if_pc goes 0,1,2 with if_instr 0x10000000..0x10000002.
  - if_valid=1 from cycle 2.
- Stall high for 3 cycles while if_pc=5: pc=6 and if_pc=5/if_instr held all 3 cycles. On release, if_pc=6 next edge.
- Redirect to target 40 while pc=10: next edge pc=40 and if_valid=0. Following edge if_pc=40.
- Redirect and stall asserted together, target 20: pc=20 and if_valid=0. Redirect wins.
- halt_req at pc=7:
  - state=HALTED, pc stays 7, if_valid=0.
  - Redirect to 3 is ignored.
  - Reset returns pc to 0 and state to RUN.
- Out of range:
  - pc=255 advancing: if_pc=255 valid, then state=FAULT and pc stays 255.
  - Separately, redirect to 300: state=FAULT immediately.
  - With FETCH_PERF_EN, the 4-cycle run from the first scenario gives fetch_count=3 and bubble_count=1.
